// File: rtl/mips_step_ctrl.sv
// Single-step / free-run controller for a MIPS CPU core: debounces the step button
// and run switch and turns them into one-clk cpu_en pulses.
module mips_step_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int RUN_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        halted_by_req,
    output logic [31:0] step_count
);

    localparam int DBW  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int DIVW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_HALT     = 2'b00,
        S_STEP     = 2'b01,
        S_RUN      = 2'b10,
        S_WAIT_REL = 2'b11
    } state_t;

    state_t            cur;
    logic [DIVW-1:0]   div;
    logic [1:0]        step_sync;
    logic [1:0]        run_sync;
    logic [DBW-1:0]    step_cnt;
    logic [DBW-1:0]    run_cnt;
    logic              db_step;
    logic              db_step_prev;
    logic              db_run;
    logic              step_press;

    assign state = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_sync <= 2'b00;
            run_sync  <= 2'b00;
        end else begin
            step_sync <= {step_sync[0], step_btn};
            run_sync  <= {run_sync[0], run_sw};
        end
    end

    // A debounced value only moves after the synchronized input has disagreed
    // with it for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt     <= '0;
            db_step      <= 1'b0;
            db_step_prev <= 1'b0;
        end else begin
            db_step_prev <= db_step;
            if (step_sync[1] == db_step) begin
                step_cnt <= '0;
            end else if (step_cnt == DB_LAST) begin
                db_step  <= step_sync[1];
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
            db_run  <= 1'b0;
        end else begin
            if (run_sync[1] == db_run) begin
                run_cnt <= '0;
            end else if (run_cnt == DB_LAST) begin
                db_run  <= run_sync[1];
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    assign step_press = db_step & ~db_step_prev;

    // halt_req and a dropped run switch both veto the RUN pulse in the cycle they occur.
    assign cpu_en = (cur == S_STEP) ||
                    ((cur == S_RUN) && (div == DIV_LAST) && !halt_req && db_run);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur           <= S_HALT;
            div           <= '0;
            halted_by_req <= 1'b0;
        end else begin
            case (cur)
                S_HALT: begin
                    if (!db_run) begin
                        halted_by_req <= 1'b0;
                    end
                    if (step_press) begin
                        cur <= S_STEP;
                    end else if (db_run && !halted_by_req) begin
                        cur <= S_RUN;
                        div <= '0;
                    end
                end
                S_STEP: begin
                    cur <= S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!db_step) begin
                        cur <= S_HALT;
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        cur           <= S_HALT;
                        halted_by_req <= 1'b1;
                    end else if (!db_run) begin
                        cur <= S_HALT;
                    end else if (div == DIV_LAST) begin
                        div <= '0;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    cur <= S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_count <= 32'd0;
        end else if (cpu_en) begin
            step_count <= step_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Directed bench for mips_step_ctrl: a cycle model of the step/run rules checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_mips_step_ctrl;

    localparam int DB  = 4;
    localparam int DIV = 3;
    localparam logic [1:0] M_HALT = 2'b00;
    localparam logic [1:0] M_STEP = 2'b01;
    localparam logic [1:0] M_RUN  = 2'b10;
    localparam logic [1:0] M_WAIT = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_btn = 1'b0;
    logic        run_sw = 1'b0;
    logic        halt_req = 1'b0;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted_by_req;
    logic [31:0] step_count;

    int n_vec = 0;
    int n_fail = 0;
    bit done = 1'b0;
    bit prev_en = 1'b0;

    mips_step_ctrl #(.DB_CYCLES(DB), .RUN_DIV(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .step_btn(step_btn),
        .run_sw(run_sw),
        .halt_req(halt_req),
        .cpu_en(cpu_en),
        .state(state),
        .halted_by_req(halted_by_req),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [1:0]  m_mode = M_HALT;
    int          m_run_cyc = 0;
    bit          m_flag = 1'b0;
    logic [31:0] m_count = 32'd0;
    bit          m_sd1 = 0, m_sd2 = 0, m_rd1 = 0, m_rd2 = 0;
    bit          m_sdb = 0, m_sdb_prev = 0, m_rdb = 0;
    int          m_sstreak = 0, m_rstreak = 0;

    function automatic bit m_en();
        return (m_mode == M_STEP) ||
               (m_mode == M_RUN && (m_run_cyc % DIV) == DIV - 1 && !halt_req && m_rdb);
    endfunction

    task automatic deb(input bit s, inout bit db, inout int streak);
        if (s == db) streak = 0;
        else if (streak == DB - 1) begin
            db = s;
            streak = 0;
        end else streak = streak + 1;
    endtask

    task automatic model_reset();
        m_mode = M_HALT; m_run_cyc = 0; m_flag = 0; m_count = 32'd0;
        m_sd1 = 0; m_sd2 = 0; m_rd1 = 0; m_rd2 = 0;
        m_sdb = 0; m_sdb_prev = 0; m_rdb = 0; m_sstreak = 0; m_rstreak = 0;
    endtask

    task automatic model_step();
        bit press;
        if (m_en()) m_count = m_count + 32'd1;
        press = m_sdb && !m_sdb_prev;
        case (m_mode)
            M_HALT: begin
                if (!m_rdb) m_flag = 0;
                if (press) m_mode = M_STEP;
                else if (m_rdb && !m_flag) begin
                    m_mode = M_RUN;
                    m_run_cyc = 0;
                end
            end
            M_STEP: m_mode = M_WAIT;
            M_WAIT: if (!m_sdb) m_mode = M_HALT;
            default: begin
                if (halt_req) begin
                    m_mode = M_HALT;
                    m_flag = 1;
                end else if (!m_rdb) m_mode = M_HALT;
                else m_run_cyc = m_run_cyc + 1;
            end
        endcase
        m_sdb_prev = m_sdb;
        deb(m_sd2, m_sdb, m_sstreak);
        deb(m_rd2, m_rdb, m_rstreak);
        m_sd2 = m_sd1; m_sd1 = step_btn;
        m_rd2 = m_rd1; m_rd1 = run_sw;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            check("state", {30'd0, state}, {30'd0, m_mode});
            check("cpu_en", {31'd0, cpu_en}, {31'd0, m_en()});
            check("halted_by_req", {31'd0, halted_by_req}, {31'd0, m_flag});
            check("step_count", step_count, m_count);
            check("no_adjacent_en", {31'd0, prev_en & cpu_en}, 32'd0);
            prev_en = reset ? 1'b0 : cpu_en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_run_phase(input int ph, input string nm);
        int k;
        k = 0;
        while (!(m_mode == M_RUN && (m_run_cyc % DIV) == ph) && k < 50) begin
            cycles(1);
            k++;
        end
        n_vec++;
        if (k >= 50) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for RUN phase %0d, state %0d", nm, ph, state);
        end
    endtask

    initial begin
        cycles(3);
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("reset_count", step_count, 32'd0);
        reset = 1'b0;

        // short glitch on the button
        step_btn = 1'b1; cycles(2); step_btn = 1'b0;
        cycles(10);
        check("glitch_state", {30'd0, state}, 32'd0);
        check("glitch_count", step_count, 32'd0);

        // clean step press: STEP after sync + debounce + edge detect
        step_btn = 1'b1; cycles(7);
        check("step_state_step", {30'd0, state}, 32'd1);
        check("step_cpu_en", {31'd0, cpu_en}, 32'd1);
        cycles(1);
        check("step_state_wait", {30'd0, state}, 32'd3);
        check("step_count_1", step_count, 32'd1);
        cycles(12);
        check("step_hold_count", step_count, 32'd1);
        step_btn = 1'b0; cycles(10);
        check("step_back_halt", {30'd0, state}, 32'd0);

        // free run
        run_sw = 1'b1; cycles(30);
        check("run_state", {30'd0, state}, 32'd2);
        run_sw = 1'b0; cycles(15);
        check("run_off_state", {30'd0, state}, 32'd0);

        // halt_req in a divider=2 cycle
        run_sw = 1'b1;
        wait_run_phase(2, "halt_req_wait");
        halt_req = 1'b1; #1;
        check("halt_req_no_en", {31'd0, cpu_en}, 32'd0);
        cycles(1);
        halt_req = 1'b0;
        check("halt_req_state", {30'd0, state}, 32'd0);
        check("halt_req_flag", {31'd0, halted_by_req}, 32'd1);
        cycles(20);
        check("flag_blocks_run", {30'd0, state}, 32'd0);
        run_sw = 1'b0; cycles(12);
        check("flag_cleared", {31'd0, halted_by_req}, 32'd0);
        run_sw = 1'b1; cycles(12);
        check("run_resumed", {30'd0, state}, 32'd2);

        // async reset with divider=1
        wait_run_phase(1, "reset_wait");
        reset = 1'b1; #1;
        check("async_rst_state", {30'd0, state}, 32'd0);
        check("async_rst_en", {31'd0, cpu_en}, 32'd0);
        check("async_rst_count", step_count, 32'd0);
        run_sw = 1'b0;
        cycles(2);
        reset = 1'b0;

        // full debounce period needed after reset
        run_sw = 1'b1; cycles(6);
        check("post_rst_no_run", {30'd0, state}, 32'd0);
        cycles(2);
        check("post_rst_run", {30'd0, state}, 32'd2);
        run_sw = 1'b0; cycles(12);

        // step_count wrap
        force dut.step_count = 32'hFFFF_FFFF;
        #1;
        release dut.step_count;
        m_count = 32'hFFFF_FFFF;
        cycles(1);
        check("preload_count", step_count, 32'hFFFF_FFFF);
        step_btn = 1'b1; cycles(12);
        step_btn = 1'b0; cycles(12);
        check("wrap_count", step_count, 32'd0);
        check("wrap_state", {30'd0, state}, 32'd0);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
